inst_axi_rd_bridge: RTL

//   Slave on the fetch-side sram-like port (req/addr_ok/data_ok); master on an AXI3 read-only channel.

---
 rtl/inst_axi_rd_bridge_pkg.sv | 17 +
 rtl/inst_axi_rd_bridge_if.sv | 36 +++
 rtl/inst_axi_rd_bridge_ost_ctr.sv | 45 ++++
 rtl/inst_axi_rd_bridge.sv | 117 +++++++++++
 4 files changed

// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared constants and types for the instruction-fetch AXI read bridge.
package inst_axi_rd_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_WAIT = 1'b1
    } ar_state_t;

    // sram-like size code (0/1/2 = 1/2/4 bytes) maps straight onto AXI arsize
    function automatic logic [2:0] size_to_arsize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/inst_axi_rd_bridge_if.sv
// AXI3 read-only channel (AR + R) between the fetch bridge and the memory side.
interface inst_axi_rd_bridge_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/inst_axi_rd_bridge_ost_ctr.sv
// Outstanding-read and pending-drop counters for the fetch bridge.
// drop counts the oldest outstanding reads whose data must be discarded.
module ibridge_ost_ctr #(
    parameter int unsigned MAX_OST = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic ret,
    input  logic cancel,
    output logic full,
    output logic drop_nz
);

    localparam int unsigned CNT_W = $clog2(MAX_OST + 1);

    logic [CNT_W-1:0] ost;
    logic [CNT_W-1:0] drop;

    // Outstanding count: issue increments, retire decrements, both cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            ost <= '0;
        end else if (inc && !ret) begin
            ost <= ost + CNT_W'(1);
        end else if (!inc && ret) begin
            ost <= ost - CNT_W'(1);
        end
    end

    // Drop count: a cancel marks every read still outstanding after this cycle's retire
    always_ff @(posedge clk) begin
        if (reset) begin
            drop <= '0;
        end else if (cancel) begin
            drop <= ost - CNT_W'(ret);
        end else if (ret && (drop != '0)) begin
            drop <= drop - CNT_W'(1);
        end
    end

    assign full    = (ost == CNT_W'(MAX_OST));
    assign drop_nz = (drop != '0);

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-fetch bridge: sram-like slave port to AXI3 read-only master.
// Optional feature macro: IBRIDGE_RRESP_CHK_EN adds inst_bus_err (error response on a live beat).
module inst_axi_rd_bridge
    import inst_axi_rd_bridge_pkg::*;
#(
    parameter int unsigned MAX_OST = 2,
    parameter logic [3:0]  AXI_ID  = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        ws_cancel,
`ifdef IBRIDGE_RRESP_CHK_EN
    output logic        inst_bus_err,
`endif
    inst_axi_rd_bridge_if.master axi
);

    ar_state_t   ar_state_q;
    ar_state_t   ar_state_d;
    logic [31:0] araddr_q;
    logic [2:0]  arsize_q;
    logic        rready_q;
    logic        ret;
    logic        full;
    logic        drop_nz;

    // AR state register
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state_q <= AR_IDLE;
        end else begin
            ar_state_q <= ar_state_d;
        end
    end

    // Request acceptance and AR next state
    always_comb begin
        ar_state_d   = ar_state_q;
        inst_addr_ok = 1'b0;
        unique case (ar_state_q)
            AR_IDLE: begin
                inst_addr_ok = !reset && inst_req && !inst_wr && !full && !ws_cancel;
                if (inst_addr_ok) begin
                    ar_state_d = AR_WAIT;
                end
            end
            AR_WAIT: begin
                if (axi.arready) begin
                    ar_state_d = AR_IDLE;
                end
            end
            default: ar_state_d = AR_IDLE;
        endcase
    end

    // Capture address/size of the accepted request; rready rises once out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            araddr_q <= '0;
            arsize_q <= '0;
            rready_q <= 1'b0;
        end else begin
            rready_q <= 1'b1;
            if (inst_addr_ok) begin
                araddr_q <= inst_addr;
                arsize_q <= size_to_arsize(inst_size);
            end
        end
    end

    ibridge_ost_ctr #(
        .MAX_OST (MAX_OST)
    ) u_ost_ctr (
        .clk     (clk),
        .reset   (reset),
        .inc     (inst_addr_ok),
        .ret     (ret),
        .cancel  (ws_cancel),
        .full    (full),
        .drop_nz (drop_nz)
    );

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = '0;
    assign axi.arsize  = arsize_q;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = '0;
    assign axi.arcache = '0;
    assign axi.arprot  = '0;
    assign axi.arvalid = (ar_state_q == AR_WAIT);
    assign axi.rready  = rready_q;

    assign ret          = axi.rvalid && rready_q;
    assign inst_data_ok = ret && !drop_nz;
    assign inst_rdata   = axi.rdata;

`ifdef IBRIDGE_RRESP_CHK_EN
    assign inst_bus_err = inst_data_ok && (axi.rresp != AXI_RESP_OKAY);

    logic unused_inputs;
    assign unused_inputs = ^{inst_wstrb, inst_wdata, axi.rid, axi.rlast};
`else
    logic unused_inputs;
    assign unused_inputs = ^{inst_wstrb, inst_wdata, axi.rid, axi.rlast, axi.rresp};
`endif

endmodule
